// File: rtl/vga_text_fetch.sv
`timescale 1ns/1ps
// vga_text_fetch: turns pixel coordinates into a framebuffer read and decodes the
// char/attribute word into glyph, colour indices and cursor flag two cycles later.
module vga_text_fetch #(
   parameter int SYNC_EXTRA_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        active_in,
   input  logic [8:0]  row_in,
   input  logic [9:0]  col_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [10:0] fb_addr,
   input  logic [15:0] fb_rdata,
   input  logic        blink_enable,
   input  logic        cursor_enable,
   input  logic [10:0] cursor_pos,
   input  logic [2:0]  cursor_scan_start,
   input  logic [2:0]  cursor_scan_end,
   output logic [7:0]  glyph,
   output logic [2:0]  glyph_row,
   output logic [2:0]  glyph_col,
   output logic [3:0]  foreground,
   output logic [3:0]  background,
   output logic        render_cursor,
   output logic        hsync_out,
   output logic        vsync_out
);

   localparam int          SYNC_DEPTH = 2 + SYNC_EXTRA_DELAY;
   localparam logic [10:0] CELL_COUNT = 11'd2000;

   // Glyph rows are double-scanned, so the row LSB never selects anything.
   logic unused_row_lsb;
   assign unused_row_lsb = row_in[0];

   logic [4:0]  char_row;
   logic [6:0]  char_col;
   logic [2:0]  pix_glyph_row;
   logic [10:0] cell_idx;

   assign char_row      = row_in[8:4];
   assign char_col      = col_in[9:3];
   assign pix_glyph_row = row_in[3:1];
   assign cell_idx      = ({6'd0, char_row} << 6) + ({6'd0, char_row} << 4) + {4'd0, char_col};
   assign fb_addr       = cell_idx;

   // Frame counter and cursor shadow registers
   logic        vsync_prev_q, vsync_prev_d;
   logic [4:0]  frame_cnt_q, frame_cnt_d;
   logic        sh_en_q, sh_en_d;
   logic [10:0] sh_pos_q, sh_pos_d;
   logic [2:0]  sh_start_q, sh_start_d;
   logic [2:0]  sh_end_q, sh_end_d;
   logic        vsync_rise;

   always_comb begin
      vsync_rise   = vsync_in & ~vsync_prev_q;
      vsync_prev_d = vsync_in;
      frame_cnt_d  = frame_cnt_q;
      sh_en_d      = sh_en_q;
      sh_pos_d     = sh_pos_q;
      sh_start_d   = sh_start_q;
      sh_end_d     = sh_end_q;
      if (vsync_rise) begin
         frame_cnt_d = frame_cnt_q + 5'd1;
         sh_en_d     = cursor_enable;
         sh_pos_d    = cursor_pos;
         sh_start_d  = cursor_scan_start;
         sh_end_d    = cursor_scan_end;
      end
   end

   // Stage 1: side-band values travelling alongside the RAM read
   logic       active_s1_q, active_s1_d;
   logic [2:0] grow_s1_q, grow_s1_d;
   logic [2:0] gcol_s1_q, gcol_s1_d;
   logic       cursor_s1_q, cursor_s1_d;
   logic       text_on_s1_q, text_on_s1_d;
   logic       blink_en_s1_q, blink_en_s1_d;

   always_comb begin
      active_s1_d   = active_in;
      grow_s1_d     = pix_glyph_row;
      gcol_s1_d     = col_in[2:0];
      text_on_s1_d  = frame_cnt_q[4];
      blink_en_s1_d = blink_enable;
      // Phases and shadows are the pre-edge values, so a vsync edge affects the next pixel on.
      cursor_s1_d   = sh_en_q
                      && (cell_idx == sh_pos_q)
                      && (sh_pos_q < CELL_COUNT)
                      && (sh_start_q <= pix_glyph_row)
                      && (pix_glyph_row <= sh_end_q)
                      && frame_cnt_q[3];
   end

   // Stage 2: attribute decode on the returned word
   logic [7:0] attr;
   logic       blink;
   logic [3:0] dec_bg;
   logic [3:0] dec_fg;
   logic [7:0] glyph_q, glyph_d;
   logic [2:0] glyph_row_q, glyph_row_d;
   logic [2:0] glyph_col_q, glyph_col_d;
   logic [3:0] fg_q, fg_d;
   logic [3:0] bg_q, bg_d;
   logic       cursor_q, cursor_d;

   always_comb begin
      attr        = fb_rdata[15:8];
      blink       = blink_en_s1_q & attr[7];
      dec_bg      = blink_en_s1_q ? {1'b0, attr[6:4]} : attr[7:4];
      dec_fg      = (blink && !text_on_s1_q) ? dec_bg : attr[3:0];
      glyph_row_d = grow_s1_q;
      glyph_col_d = gcol_s1_q;
      glyph_d     = 8'd0;
      fg_d        = 4'd0;
      bg_d        = 4'd0;
      cursor_d    = 1'b0;
      if (active_s1_q) begin
         glyph_d  = fb_rdata[7:0];
         fg_d     = dec_fg;
         bg_d     = dec_bg;
         cursor_d = cursor_s1_q;
      end
   end

   // Sync delay line matches the two pixel stages plus the downstream lookup
   logic [SYNC_DEPTH-1:0] hs_sr_q, hs_sr_d;
   logic [SYNC_DEPTH-1:0] vs_sr_q, vs_sr_d;

   always_comb begin
      hs_sr_d = {hs_sr_q[SYNC_DEPTH-2:0], hsync_in};
      vs_sr_d = {vs_sr_q[SYNC_DEPTH-2:0], vsync_in};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_prev_q  <= 1'b0;
         frame_cnt_q   <= 5'd0;
         sh_en_q       <= 1'b0;
         sh_pos_q      <= 11'd0;
         sh_start_q    <= 3'd0;
         sh_end_q      <= 3'd0;
         active_s1_q   <= 1'b0;
         grow_s1_q     <= 3'd0;
         gcol_s1_q     <= 3'd0;
         cursor_s1_q   <= 1'b0;
         text_on_s1_q  <= 1'b0;
         blink_en_s1_q <= 1'b0;
         glyph_q       <= 8'd0;
         glyph_row_q   <= 3'd0;
         glyph_col_q   <= 3'd0;
         fg_q          <= 4'd0;
         bg_q          <= 4'd0;
         cursor_q      <= 1'b0;
         hs_sr_q       <= '0;
         vs_sr_q       <= '0;
      end else begin
         vsync_prev_q  <= vsync_prev_d;
         frame_cnt_q   <= frame_cnt_d;
         sh_en_q       <= sh_en_d;
         sh_pos_q      <= sh_pos_d;
         sh_start_q    <= sh_start_d;
         sh_end_q      <= sh_end_d;
         active_s1_q   <= active_s1_d;
         grow_s1_q     <= grow_s1_d;
         gcol_s1_q     <= gcol_s1_d;
         cursor_s1_q   <= cursor_s1_d;
         text_on_s1_q  <= text_on_s1_d;
         blink_en_s1_q <= blink_en_s1_d;
         glyph_q       <= glyph_d;
         glyph_row_q   <= glyph_row_d;
         glyph_col_q   <= glyph_col_d;
         fg_q          <= fg_d;
         bg_q          <= bg_d;
         cursor_q      <= cursor_d;
         hs_sr_q       <= hs_sr_d;
         vs_sr_q       <= vs_sr_d;
      end
   end

   assign glyph         = glyph_q;
   assign glyph_row     = glyph_row_q;
   assign glyph_col     = glyph_col_q;
   assign foreground    = fg_q;
   assign background    = bg_q;
   assign render_cursor = cursor_q;
   assign hsync_out     = hs_sr_q[SYNC_DEPTH-1];
   assign vsync_out     = vs_sr_q[SYNC_DEPTH-1];

endmodule

// File: tb/tb_vga_text_fetch.sv
`timescale 1ns/1ps
// Bench for vga_text_fetch: vector table plus hand sequences for frame-based cursor/blink,
// sync delay and mid-frame reset; expectations travel through queues with the pixels.
module tb_vga_text_fetch;

   localparam int OUT_W = 23;

   typedef struct packed {
      logic       act;
      logic [8:0] row;
      logic [9:0] col;
      logic       ben;
      logic [7:0] g;
      logic [2:0] gr;
      logic [2:0] gc;
      logic [3:0] fg;
      logic [3:0] bg;
      logic       cur;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        active_in = 1'b0;
   logic [8:0]  row_in = '0;
   logic [9:0]  col_in = '0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic [10:0] fb_addr;
   logic [15:0] fb_rdata = '0;
   logic        blink_enable = 1'b1;
   logic        cursor_enable = 1'b0;
   logic [10:0] cursor_pos = '0;
   logic [2:0]  cursor_scan_start = '0;
   logic [2:0]  cursor_scan_end = '0;
   logic [7:0]  glyph;
   logic [2:0]  glyph_row;
   logic [2:0]  glyph_col;
   logic [3:0]  foreground;
   logic [3:0]  background;
   logic        render_cursor;
   logic        hsync_out;
   logic        vsync_out;

   logic [15:0]      mem [0:2047];
   logic [OUT_W-1:0] exp_q[$];
   string            name_q[$];
   logic [1:0]       sync_q[$];
   int               checks = 0;
   int               errors = 0;
   logic [4:0]       frames = '0;
   vec_t             vecs [9];
   logic [3:0]       hs_exp = 4'b0100;

   vga_text_fetch #(.SYNC_EXTRA_DELAY(1)) dut (
      .clk               (clk),
      .reset             (reset),
      .active_in         (active_in),
      .row_in            (row_in),
      .col_in            (col_in),
      .hsync_in          (hsync_in),
      .vsync_in          (vsync_in),
      .fb_addr           (fb_addr),
      .fb_rdata          (fb_rdata),
      .blink_enable      (blink_enable),
      .cursor_enable     (cursor_enable),
      .cursor_pos        (cursor_pos),
      .cursor_scan_start (cursor_scan_start),
      .cursor_scan_end   (cursor_scan_end),
      .glyph             (glyph),
      .glyph_row         (glyph_row),
      .glyph_col         (glyph_col),
      .foreground        (foreground),
      .background        (background),
      .render_cursor     (render_cursor),
      .hsync_out         (hsync_out),
      .vsync_out         (vsync_out)
   );

   // Clock and one-cycle-latency framebuffer RAM
   always #5 clk = ~clk;
   always @(posedge clk) fb_rdata <= mem[fb_addr];

   function automatic logic [OUT_W-1:0] pk(input logic [7:0] g, input logic [2:0] gr,
                                           input logic [2:0] gc, input logic [3:0] fg,
                                           input logic [3:0] bg, input logic cur);
      return {g, gr, gc, fg, bg, cur};
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_glyph"}, 32'(glyph), 32'd0);
      check({tag, "_glyph_row"}, 32'(glyph_row), 32'd0);
      check({tag, "_glyph_col"}, 32'(glyph_col), 32'd0);
      check({tag, "_fg"}, 32'(foreground), 32'd0);
      check({tag, "_bg"}, 32'(background), 32'd0);
      check({tag, "_cursor"}, 32'(render_cursor), 32'd0);
      check({tag, "_hsync"}, 32'(hsync_out), 32'd0);
      check({tag, "_vsync"}, 32'(vsync_out), 32'd0);
   endtask

   // After reset the output stage holds zeros for one sample and the sync line for two.
   task automatic restart_queues();
      exp_q.delete();
      name_q.delete();
      sync_q.delete();
      exp_q.push_back('0);
      name_q.push_back("post_reset");
      sync_q.push_back(2'b00);
      sync_q.push_back(2'b00);
   endtask

   task automatic step(input logic act, input logic [8:0] r, input logic [9:0] c,
                       input logic hs, input logic vs, input logic [OUT_W-1:0] exp,
                       input string nm);
      logic [OUT_W-1:0] e;
      logic [1:0]       s;
      string            n;
      active_in = act;
      row_in    = r;
      col_in    = c;
      hsync_in  = hs;
      vsync_in  = vs;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      sync_q.push_back({vs, hs});
      @(posedge clk);
      #1;
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, 32'({glyph, glyph_row, glyph_col, foreground, background, render_cursor}),
               32'(e));
      end
      if (sync_q.size() >= 3) begin
         s = sync_q.pop_front();
         check("hsync_out", 32'(hsync_out), 32'(s[0]));
         check("vsync_out", 32'(vsync_out), 32'(s[1]));
      end
   endtask

   task automatic pix(input logic [8:0] r, input logic [9:0] c, input logic [7:0] g,
                      input logic [2:0] gr, input logic [2:0] gc, input logic [3:0] fg,
                      input logic [3:0] bg, input logic cur, input string nm);
      step(1'b1, r, c, 1'b0, 1'b0, pk(g, gr, gc, fg, bg, cur), nm);
   endtask

   task automatic idle();
      step(1'b0, 9'd0, 10'd0, 1'b0, 1'b0, '0, "idle");
   endtask

   task automatic vsync_to(input logic [4:0] target);
      while (frames != target) begin
         step(1'b0, 9'd0, 10'd0, 1'b0, 1'b1, '0, "vs_hi");
         step(1'b0, 9'd0, 10'd0, 1'b0, 1'b0, '0, "vs_lo");
         frames = frames + 5'd1;
      end
   endtask

   task automatic addr_chk(input logic [8:0] r, input logic [9:0] c, input logic [10:0] exp,
                           input string nm);
      row_in = r;
      col_in = c;
      #1;
      check(nm, 32'(fb_addr), 32'(exp));
   endtask

   initial begin
      vecs[0] = '{1'b1, 9'd2,   10'd5,   1'b1, 8'h41, 3'd1, 3'd5, 4'hE, 4'h1, 1'b0};
      vecs[1] = '{1'b1, 9'd399, 10'd639, 1'b1, 8'h7E, 3'd7, 3'd7, 4'hA, 4'h2, 1'b0};
      vecs[2] = '{1'b1, 9'd17,  10'd10,  1'b1, 8'h43, 3'd0, 3'd2, 4'h7, 4'h0, 1'b0};
      vecs[3] = '{1'b1, 9'd5,   10'd43,  1'b1, 8'h58, 3'd2, 3'd3, 4'h1, 4'h1, 1'b0};
      vecs[4] = '{1'b1, 9'd5,   10'd43,  1'b0, 8'h58, 3'd2, 3'd3, 4'hF, 4'h9, 1'b0};
      vecs[5] = '{1'b0, 9'd2,   10'd5,   1'b1, 8'h00, 3'd1, 3'd5, 4'h0, 4'h0, 1'b0};
      vecs[6] = '{1'b1, 9'd28,  10'd8,   1'b1, 8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b0};
      vecs[7] = '{1'b1, 9'd16,  10'd0,   1'b1, 8'h44, 3'd0, 3'd0, 4'h7, 4'h0, 1'b0};
      vecs[8] = '{1'b1, 9'd19,  10'd23,  1'b1, 8'h45, 3'd1, 3'd7, 4'hC, 4'h4, 1'b0};

      for (int i = 0; i < 2048; i++) mem[i] = 16'h0700 | 16'(i & 255);
      mem[0]    = 16'h1E41;
      mem[5]    = 16'h9F58;
      mem[80]   = 16'h0744;
      mem[81]   = 16'h0743;
      mem[82]   = 16'h4C45;
      mem[1999] = 16'h2A7E;
      mem[2000] = 16'h0731;

      // Reset state and combinational address map
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      addr_chk(9'd399, 10'd639, 11'd1999, "addr_last");
      addr_chk(9'd16, 10'd8, 11'd81, "addr_81");
      addr_chk(9'd200, 10'd320, 11'd1000, "addr_1000");
      addr_chk(9'd15, 10'd7, 11'd0, "addr_cell0_edge");
      reset = 1'b0;
      restart_queues();

      // Cursor programmed but not yet latched by any vsync edge
      cursor_enable     = 1'b1;
      cursor_pos        = 11'd81;
      cursor_scan_start = 3'd6;
      cursor_scan_end   = 3'd7;

      for (int i = 0; i < 9; i++) begin
         blink_enable = vecs[i].ben;
         step(vecs[i].act, vecs[i].row, vecs[i].col, 1'b0, 1'b0,
              pk(vecs[i].g, vecs[i].gr, vecs[i].gc, vecs[i].fg, vecs[i].bg, vecs[i].cur),
              $sformatf("vec%0d", i));
      end
      blink_enable = 1'b1;
      idle();
      idle();

      // Cursor phase on, shadow latched
      vsync_to(5'd8);
      pix(9'd28, 10'd8,  8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b1, "cur_hit_r6");
      pix(9'd31, 10'd15, 8'h43, 3'd7, 3'd7, 4'h7, 4'h0, 1'b1, "cur_hit_r7");
      pix(9'd26, 10'd8,  8'h43, 3'd5, 3'd0, 4'h7, 4'h0, 1'b0, "cur_row5");
      pix(9'd28, 10'd0,  8'h44, 3'd6, 3'd0, 4'h7, 4'h0, 1'b0, "cur_cell80");
      pix(9'd28, 10'd16, 8'h45, 3'd6, 3'd0, 4'hC, 4'h4, 1'b0, "cur_cell82");
      step(1'b0, 9'd28, 10'd8, 1'b0, 1'b0, pk(8'h00, 3'd6, 3'd0, 4'h0, 4'h0, 1'b0), "cur_inactive");
      pix(9'd5, 10'd43, 8'h58, 3'd2, 3'd3, 4'h1, 4'h1, 1'b0, "blink_text_off");

      // Position change waits for the next frame
      cursor_pos = 11'd82;
      pix(9'd28, 10'd8,  8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b1, "pos_old_still");
      pix(9'd28, 10'd16, 8'h45, 3'd6, 3'd0, 4'hC, 4'h4, 1'b0, "pos_new_pending");
      vsync_to(5'd9);
      pix(9'd28, 10'd16, 8'h45, 3'd6, 3'd0, 4'hC, 4'h4, 1'b1, "pos_new_live");
      pix(9'd28, 10'd8,  8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b0, "pos_old_gone");

      // Inverted scan range never renders
      cursor_scan_start = 3'd7;
      cursor_scan_end   = 3'd2;
      vsync_to(5'd10);
      pix(9'd20, 10'd16, 8'h45, 3'd2, 3'd0, 4'hC, 4'h4, 1'b0, "inv_range_r2");
      pix(9'd24, 10'd16, 8'h45, 3'd4, 3'd0, 4'hC, 4'h4, 1'b0, "inv_range_r4");
      pix(9'd30, 10'd16, 8'h45, 3'd7, 3'd0, 4'hC, 4'h4, 1'b0, "inv_range_r7");

      // Position 2000 is off-screen and never matches, even for an out-of-range row
      cursor_pos        = 11'd2000;
      cursor_scan_start = 3'd0;
      cursor_scan_end   = 3'd7;
      vsync_to(5'd11);
      pix(9'd400, 10'd0, 8'h31, 3'd0, 3'd0, 4'h7, 4'h0, 1'b0, "pos2000");
      pix(9'd28, 10'd16, 8'h45, 3'd6, 3'd0, 4'hC, 4'h4, 1'b0, "pos2000_cell82");

      // Counter 16: cursor phase off, text phase on
      cursor_pos        = 11'd81;
      cursor_scan_start = 3'd6;
      cursor_scan_end   = 3'd7;
      vsync_to(5'd16);
      pix(9'd28, 10'd8, 8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b0, "cur_phase_off");
      pix(9'd5, 10'd43, 8'h58, 3'd2, 3'd3, 4'hF, 4'h1, 1'b0, "blink_text_on");
      blink_enable = 1'b0;
      pix(9'd5, 10'd43, 8'h58, 3'd2, 3'd3, 4'hF, 4'h9, 1'b0, "no_blink_f16");
      blink_enable = 1'b1;

      vsync_to(5'd24);
      pix(9'd28, 10'd8, 8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b1, "cur_phase_on24");
      pix(9'd5, 10'd43, 8'h58, 3'd2, 3'd3, 4'hF, 4'h1, 1'b0, "blink_on24");

      cursor_enable = 1'b0;
      vsync_to(5'd25);
      pix(9'd28, 10'd8, 8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b0, "cur_disabled");
      cursor_enable = 1'b1;
      vsync_to(5'd26);
      pix(9'd28, 10'd8, 8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b1, "cur_reenabled");

      // hsync pulse reappears exactly three cycles later
      step(1'b0, 9'd0, 10'd0, 1'b1, 1'b0, '0, "hs_pulse");
      check("hs_lat1", 32'(hsync_out), 32'(hs_exp[0]));
      for (int i = 1; i < 4; i++) begin
         idle();
         check($sformatf("hs_lat%0d", i + 1), 32'(hsync_out), 32'(hs_exp[i]));
      end

      // Mid-frame reset; the hsync driven two cycles earlier must be discarded too
      step(1'b1, 9'd28, 10'd8, 1'b1, 1'b0, pk(8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b1), "pre_reset_a");
      pix(9'd28, 10'd8, 8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b1, "pre_reset_b");
      reset     = 1'b1;
      active_in = 1'b1;
      row_in    = 9'd2;
      col_in    = 10'd5;
      hsync_in  = 1'b1;
      @(posedge clk);
      #1;
      check_zero("reset_mid");
      reset  = 1'b0;
      frames = '0;
      restart_queues();
      pix(9'd28, 10'd8, 8'h43, 3'd6, 3'd0, 4'h7, 4'h0, 1'b0, "post_reset_cur_off");
      pix(9'd5, 10'd43, 8'h58, 3'd2, 3'd3, 4'h1, 4'h1, 1'b0, "post_reset_blink");
      pix(9'd2, 10'd5,  8'h41, 3'd1, 3'd5, 4'hE, 4'h1, 1'b0, "post_reset_decode");
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
